// File: rtl/coax_bus_pkg.sv
// Shared types and widths for the coax bus host controller.
// No logic; consumed by coax_bus_host and its sub-modules.
// No flow control.
package coax_bus_pkg;

    localparam int WORD_WIDTH  = 10;
    localparam int STATS_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_SETUP = 3'd1,
        ST_TX_LOAD  = 3'd2,
        ST_TX_HOLD  = 3'd3,
        ST_RX_TURN  = 3'd4,
        ST_RX_READ  = 3'd5,
        ST_RX_HOLD  = 3'd6
    } state_t;

endpackage

// File: rtl/coax_bus_sync.sv
// Multi-flop synchroniser for one asynchronous status bit.
// Latency: STAGES clk cycles from input change to q.
// No backpressure; level signal only.
module coax_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/coax_bus_host.sv
// Host-side coax bus controller: tx words to tx_load strobes, rx via rx_enable/rx_data_read. Optional COAX_BUS_HOST_STATS_EN adds counters.
// Latency: tx accept -> tx_load in cycles 2..PULSE_CYCLES+1; rx capture on first rx_data_read cycle.
// Backpressure: tx_ready gated by synced tx_full and pending rx; no rx capture while rx_valid is held.
module coax_bus_host
    import coax_bus_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int PULSE_CYCLES      = 3,
    parameter int HOLDOFF_CYCLES    = 4,
    parameter int TURNAROUND_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WORD_WIDTH-1:0]  tx_word,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [WORD_WIDTH-1:0]  rx_word,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   tx_load,
    input  logic                   tx_full,
    output logic                   rx_enable,
    input  logic                   rx_data_available,
    output logic                   rx_data_read,
    input  logic                   rx_active,
    output logic                   rx_active_s,
    input  logic [WORD_WIDTH-1:0]  data_in,
    output logic [WORD_WIDTH-1:0]  data_out,
    output logic                   data_oe,
`ifdef COAX_BUS_HOST_STATS_EN
    input  logic                   stats_clear,
    output logic [STATS_WIDTH-1:0] tx_count,
    output logic [STATS_WIDTH-1:0] rx_count,
`endif
    output logic                   busy
);

    localparam int CNT_MAX_A = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TURNAROUND_CYCLES) ? CNT_MAX_A : TURNAROUND_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURNAROUND_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             full_s;
    logic             avail_s;
    logic             rx_pending;
    logic             tx_accept;
    logic             rx_capture;

    coax_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_full (
        .clk(clk), .reset_n(reset_n), .d(tx_full), .q(full_s)
    );
    coax_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_avail (
        .clk(clk), .reset_n(reset_n), .d(rx_data_available), .q(avail_s)
    );
    coax_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_active (
        .clk(clk), .reset_n(reset_n), .d(rx_active), .q(rx_active_s)
    );

    // Receive wins arbitration so a waiting interface word is never starved by tx traffic.
    assign rx_pending = avail_s && !rx_valid;
    assign tx_ready   = (state == ST_IDLE) && !full_s && !rx_pending;
    assign tx_accept  = tx_valid && tx_ready;
    assign rx_capture = (state == ST_RX_READ) && (cnt == PULSE_LD);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            tx_load      <= 1'b0;
            rx_enable    <= 1'b0;
            rx_data_read <= 1'b0;
            data_oe      <= 1'b0;
            data_out     <= '0;
            rx_word      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (rx_pending) begin
                        state     <= ST_RX_TURN;
                        cnt       <= TURN_LD;
                        rx_enable <= 1'b1;
                    end else if (tx_accept) begin
                        state    <= ST_TX_SETUP;
                        data_out <= tx_word;
                        data_oe  <= 1'b1;
                    end
                end
                ST_TX_SETUP: begin
                    state   <= ST_TX_LOAD;
                    cnt     <= PULSE_LD;
                    tx_load <= 1'b1;
                end
                ST_TX_LOAD: begin
                    if (cnt == '0) begin
                        state   <= ST_TX_HOLD;
                        cnt     <= HOLD_LD;
                        tx_load <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_TX_HOLD: begin
                    // Bus stays driven for the first holdoff cycle so data outlives the strobe.
                    data_oe <= 1'b0;
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RX_TURN: begin
                    if (cnt == '0) begin
                        state        <= ST_RX_READ;
                        cnt          <= PULSE_LD;
                        rx_data_read <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RX_READ: begin
                    if (rx_capture) begin
                        rx_word  <= data_in;
                        rx_valid <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state        <= ST_RX_HOLD;
                        cnt          <= HOLD_LD;
                        rx_enable    <= 1'b0;
                        rx_data_read <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RX_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef COAX_BUS_HOST_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_count <= '0;
            rx_count <= '0;
        end else if (stats_clear) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (state == ST_IDLE && !rx_pending && tx_accept && tx_count != '1) begin
                tx_count <= tx_count + 1'b1;
            end
            if (rx_capture && rx_count != '1) begin
                rx_count <= rx_count + 1'b1;
            end
        end
    end
`endif

endmodule
